// File: rtl/ucpu_seq_pkg.sv
// rtl/ucpu_seq_pkg.sv - shared opcodes, micro-op field layout and packing helper for the sequencer
package ucpu_seq_pkg;

  localparam int MINST_WIDTH = 44;
  localparam int IMM_BITS    = 8;
  localparam int BR_BITS     = 8;
  localparam logic [4:0] TEMP_REG = 5'd16;

  localparam logic [4:0] OP_NOP    = 5'b00000;
  localparam logic [4:0] OP_ALU_LO = 5'b00001;
  localparam logic [4:0] OP_ALU_HI = 5'b00111;
  localparam logic [4:0] OP_LDI    = 5'b01000;
  localparam logic [4:0] OP_BR     = 5'b01001;
  localparam logic [4:0] OP_CMPBR  = 5'b01010;

  typedef enum logic [2:0] {
    MT_RR   = 3'b000,
    MT_LDI  = 3'b001,
    MT_ALUI = 3'b010,
    MT_CBR  = 3'b011,
    MT_BR   = 3'b100
  } mtype_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } seq_state_e;

  localparam int ARG_ALU_EN     = 0;
  localparam int ARG_ALU_OP_LSB = 1;
  localparam int ARG_REG_EN     = 4;
  localparam int ARG_REG_RW     = 5;

  localparam logic [9:0] ARGS_REG_WR  = (10'd1 << ARG_REG_EN) | (10'd1 << ARG_REG_RW);
  localparam logic [9:0] ARGS_ALU_SUB = (10'd1 << ARG_ALU_EN) | (10'd2 << ARG_ALU_OP_LSB);

  // Upper imm/target bits are always zero: only 8 meaningful bits of each exist.
  function automatic logic [MINST_WIDTH-1:0] pack_uop(
    input mtype_e             t,
    input logic [4:0]         src,
    input logic [4:0]         dst,
    input logic [IMM_BITS-1:0] imm,
    input logic [BR_BITS-1:0]  tgt,
    input logic [9:0]         args
  );
    return {t, src, dst, 3'b000, imm, 2'b00, tgt, args};
  endfunction

endpackage

// File: rtl/uop_rom.sv
// rtl/uop_rom.sv - combinational expansion of one macro instruction into its indexed micro-op
module uop_rom
  import ucpu_seq_pkg::*;
(
  input  logic [31:0]            instr,
  input  logic [1:0]             uop_idx,
  output logic [MINST_WIDTH-1:0] minstr,
  output logic                   last,
  output logic                   legal,
  output logic [1:0]             count
);

  logic [4:0] op;
  logic       imm_sel;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [7:0] imm8;
  logic [7:0] tgt_cbr;
  logic [7:0] tgt_br;
  logic [9:0] alu_args;

  assign op       = instr[31:27];
  assign imm_sel  = instr[26];
  assign rd       = {1'b0, instr[25:22]};
  assign rs1      = {1'b0, instr[21:18]};
  assign rs2      = {1'b0, instr[17:14]};
  assign imm8     = instr[7:0];
  assign tgt_cbr  = instr[15:8];
  assign tgt_br   = instr[8:1];
  assign alu_args = ARGS_REG_WR | {6'b0, op[2:0], 1'b1};

  always_comb begin
    minstr = '0;
    legal  = 1'b1;
    count  = 2'd0;
    case (op)
      OP_NOP: begin
      end
      OP_LDI: begin
        count  = 2'd1;
        minstr = pack_uop(MT_LDI, 5'd0, rd, imm8, 8'd0, ARGS_REG_WR);
      end
      OP_BR: begin
        count  = 2'd1;
        minstr = pack_uop(MT_BR, 5'd0, 5'd0, 8'd0, tgt_br, 10'd0);
      end
      OP_CMPBR: begin
        count  = 2'd1;
        minstr = pack_uop(MT_CBR, rs1, 5'd0, imm8, tgt_cbr, ARGS_ALU_SUB);
      end
      default: begin
        // op 0 is caught above, so a zero upper pair means OP_ALU_LO..OP_ALU_HI
        if (op[4:3] == 2'b00) begin
          count = 2'd3;
          case (uop_idx)
            2'd0:    minstr = pack_uop(MT_RR, rs1, TEMP_REG, 8'd0, 8'd0, ARGS_REG_WR);
            2'd1:    minstr = imm_sel ? pack_uop(MT_ALUI, 5'd0, TEMP_REG, imm8, 8'd0, alu_args)
                                      : pack_uop(MT_RR, rs2, TEMP_REG, 8'd0, 8'd0, alu_args);
            default: minstr = pack_uop(MT_RR, TEMP_REG, rd, 8'd0, 8'd0, ARGS_REG_WR);
          endcase
        end else begin
          legal = 1'b0;
        end
      end
    endcase
  end

  assign last = (count != 2'd0) && (uop_idx == count - 2'd1);

endmodule

// File: rtl/micro_inst_sequencer.sv
// rtl/micro_inst_sequencer.sv - macro-to-micro instruction sequencer with registered micro-op output
module micro_inst_sequencer
  import ucpu_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            instr_in,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  output logic [MINST_WIDTH-1:0] minstr_out,
  output logic                   minstr_valid,
  input  logic                   minstr_ready,
  input  logic                   flush,
  output logic                   illegal_instr,
  output logic                   busy
);

  seq_state_e state;
  seq_state_e state_nxt;

  logic [31:0]            instr_q;
  logic [1:0]             uop_idx;
  logic                   last_q;
  logic [MINST_WIDTH-1:0] minstr_q;
  logic                   valid_q;
  logic                   illegal_q;

  logic [31:0]            rom_instr;
  logic [1:0]             rom_idx;
  logic [MINST_WIDTH-1:0] rom_minstr;
  logic                   rom_last;
  logic                   rom_legal;
  logic [1:0]             rom_count;

  logic accept;
  logic fire;

  assign accept = instr_valid && instr_ready && !flush;
  assign fire   = valid_q && minstr_ready;

  // The ROM looks one uop ahead so the output register can be loaded without a bubble.
  assign rom_instr = (state == S_IDLE) ? instr_in : instr_q;
  assign rom_idx   = (state == S_IDLE) ? 2'd0 : uop_idx + 2'd1;

  uop_rom u_rom (
    .instr   (rom_instr),
    .uop_idx (rom_idx),
    .minstr  (rom_minstr),
    .last    (rom_last),
    .legal   (rom_legal),
    .count   (rom_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && rom_count != 2'd0) state_nxt = S_EMIT;
      S_EMIT: begin
        if (flush)               state_nxt = S_IDLE;
        else if (fire && last_q) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == S_IDLE);
    busy        = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q  <= '0;
      uop_idx  <= 2'd0;
      last_q   <= 1'b0;
      minstr_q <= '0;
      valid_q  <= 1'b0;
    end else if (flush) begin
      uop_idx  <= 2'd0;
      last_q   <= 1'b0;
      minstr_q <= '0;
      valid_q  <= 1'b0;
    end else if (state == S_IDLE) begin
      if (accept) begin
        instr_q <= instr_in;
        uop_idx <= 2'd0;
        if (rom_count != 2'd0) begin
          valid_q  <= 1'b1;
          minstr_q <= rom_minstr;
          last_q   <= rom_last;
        end
      end
    end else if (fire) begin
      if (last_q) begin
        valid_q  <= 1'b0;
        minstr_q <= '0;
        uop_idx  <= 2'd0;
        last_q   <= 1'b0;
      end else begin
        uop_idx  <= uop_idx + 2'd1;
        minstr_q <= rom_minstr;
        last_q   <= rom_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= accept && !rom_legal;
  end

  assign minstr_out    = minstr_q;
  assign minstr_valid  = valid_q;
  assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_micro_inst_sequencer.sv
// tb/tb_micro_inst_sequencer.sv - self-checking bench with a queue-based expansion model
module tb_micro_inst_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic [43:0] minstr_out;
  logic        minstr_valid;
  logic        minstr_ready;
  logic        flush;
  logic        illegal_instr;
  logic        busy;

  micro_inst_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .instr_in      (instr_in),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .minstr_out    (minstr_out),
    .minstr_valid  (minstr_valid),
    .minstr_ready  (minstr_ready),
    .flush         (flush),
    .illegal_instr (illegal_instr),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit mon_en = 1'b0;
  bit ill_pend = 1'b0;

  logic [43:0] exp_q[$];
  logic [43:0] seen_q[$];
  int          seen_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [43:0] mk(input int t, input int src, input int dst,
                                     input int imm, input int tgt, input int args);
    logic [63:0] w;
    w = (64'(t) << 41) | (64'(src) << 36) | (64'(dst) << 31) |
        (64'(imm) << 20) | (64'(tgt) << 10) | 64'(args);
    return w[43:0];
  endfunction

  function automatic bit is_illegal(input logic [31:0] ins);
    int op;
    op = int'(ins >> 27);
    return op > 10;
  endfunction

  task automatic push_expected(input logic [31:0] ins);
    int op, rd, rs1, rs2, imm8;
    op   = int'(ins >> 27);
    rd   = int'((ins >> 22) & 15);
    rs1  = int'((ins >> 18) & 15);
    rs2  = int'((ins >> 14) & 15);
    imm8 = int'(ins & 255);
    if (op >= 1 && op <= 7) begin
      exp_q.push_back(mk(0, rs1, 16, 0, 0, 'h30));
      if (ins[26]) exp_q.push_back(mk(2, 0, 16, imm8, 0, 'h31 + 2 * op));
      else         exp_q.push_back(mk(0, rs2, 16, 0, 0, 'h31 + 2 * op));
      exp_q.push_back(mk(0, 16, rd, 0, 0, 'h30));
    end else if (op == 8) begin
      exp_q.push_back(mk(1, 0, rd, imm8, 0, 'h30));
    end else if (op == 9) begin
      exp_q.push_back(mk(4, 0, 0, 0, int'((ins >> 1) & 255), 0));
    end else if (op == 10) begin
      exp_q.push_back(mk(3, rs1, 0, imm8, int'((ins >> 8) & 255), 5));
    end
  endtask

  // Scoreboard: sequencer is idle exactly when the model has no pending micro-ops.
  always @(negedge clk) begin
    if (mon_en) begin
      bit idle_m;
      bit ill_nxt;
      idle_m  = (exp_q.size() == 0);
      ill_nxt = 1'b0;
      chk("minstr_valid", 64'(minstr_valid), 64'(!idle_m));
      chk("instr_ready", 64'(instr_ready), 64'(idle_m));
      chk("busy", 64'(busy), 64'(!idle_m));
      chk("illegal_instr", 64'(illegal_instr), 64'(ill_pend));
      if (minstr_valid && !idle_m) chk("minstr_out", 64'(minstr_out), 64'(exp_q[0]));
      if (rst || flush) begin
        exp_q.delete();
      end else begin
        if (minstr_valid && minstr_ready) begin
          seen_q.push_back(minstr_out);
          seen_cyc.push_back(cyc);
          if (!idle_m) void'(exp_q.pop_front());
        end
        if (instr_valid && idle_m) begin
          push_expected(instr_in);
          ill_nxt = is_illegal(instr_in);
        end
      end
      ill_pend = ill_nxt;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] ins);
    int k;
    instr_in    = ins;
    instr_valid = 1'b1;
    k = 0;
    while (!instr_ready && k < 100) begin
      step(1);
      k++;
    end
    if (k >= 100) chk("send_timeout", 64'd0, 64'd1);
    acc_cyc = cyc;
    step(1);
    instr_valid = 1'b0;
    instr_in    = $urandom;
  endtask

  logic [43:0] w_exp;
  logic [31:0] ins;

  initial begin
    rst = 1'b1; instr_in = '0; instr_valid = 1'b0; minstr_ready = 1'b0; flush = 1'b0;
    step(3);
    chk("rst_minstr_out", 64'(minstr_out), 64'd0);
    chk("rst_minstr_valid", 64'(minstr_valid), 64'd0);
    chk("rst_instr_ready", 64'(instr_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_illegal", 64'(illegal_instr), 64'd0);
    rst = 1'b0; mon_en = 1'b1;
    step(1);

    // ADD r3=r1+r2, ready held high: back-to-back uops, ready returns after the third
    minstr_ready = 1'b1;
    seen_q.delete(); seen_cyc.delete();
    send(32'h08C48000);
    step(2);
    chk("add_ready_busy", 64'(instr_ready), 64'd0);
    step(1);
    chk("add_ready_back", 64'(instr_ready), 64'd1);
    chk("add_count", 64'(seen_q.size()), 64'd3);
    if (seen_q.size() == 3) begin
      w_exp = {3'b000, 5'd1, 5'd16, 3'b000, 8'h00, 2'b00, 8'h00, 10'h030};
      chk("add_u0", 64'(seen_q[0]), 64'(w_exp));
      w_exp = {3'b000, 5'd2, 5'd16, 3'b000, 8'h00, 2'b00, 8'h00, 10'h033};
      chk("add_u1", 64'(seen_q[1]), 64'(w_exp));
      w_exp = {3'b000, 5'd16, 5'd3, 3'b000, 8'h00, 2'b00, 8'h00, 10'h030};
      chk("add_u2", 64'(seen_q[2]), 64'(w_exp));
      chk("add_u0_cyc", 64'(seen_cyc[0]), 64'(acc_cyc + 1));
      chk("add_u2_cyc", 64'(seen_cyc[2]), 64'(acc_cyc + 3));
    end

    // ADDI r5=r4+0x7F
    seen_q.delete();
    send({5'b00001, 1'b1, 4'd5, 4'd4, 10'd0, 8'h7F});
    step(4);
    chk("addi_count", 64'(seen_q.size()), 64'd3);
    if (seen_q.size() == 3) begin
      w_exp = {3'b010, 5'd0, 5'd16, 3'b000, 8'h7F, 2'b00, 8'h00, 10'h033};
      chk("addi_u1", 64'(seen_q[1]), 64'(w_exp));
      w_exp = {3'b000, 5'd16, 5'd5, 3'b000, 8'h00, 2'b00, 8'h00, 10'h030};
      chk("addi_u2", 64'(seen_q[2]), 64'(w_exp));
    end

    // CMPBR rs1=2 imm=0x10 tgt=0x40
    seen_q.delete();
    send({5'b01010, 1'b0, 4'd0, 4'd2, 2'b00, 8'h40, 8'h10});
    step(2);
    chk("cmpbr_count", 64'(seen_q.size()), 64'd1);
    if (seen_q.size() == 1) begin
      w_exp = {3'b011, 5'd2, 5'd0, 3'b000, 8'h10, 2'b00, 8'h40, 10'h005};
      chk("cmpbr_u0", 64'(seen_q[0]), 64'(w_exp));
    end

    // ADD stalled for 5 cycles on u1
    seen_q.delete();
    send(32'h08C48000);
    step(1);
    minstr_ready = 1'b0;
    step(5);
    minstr_ready = 1'b1;
    step(4);
    chk("stall_count", 64'(seen_q.size()), 64'd3);
    if (seen_q.size() == 3) begin
      w_exp = {3'b000, 5'd2, 5'd16, 3'b000, 8'h00, 2'b00, 8'h00, 10'h033};
      chk("stall_u1", 64'(seen_q[1]), 64'(w_exp));
    end

    // flush during u1, then LDI r7=0xAA
    send(32'h08C48000);
    step(1);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_valid", 64'(minstr_valid), 64'd0);
    chk("flush_ready", 64'(instr_ready), 64'd1);
    chk("flush_busy", 64'(busy), 64'd0);
    seen_q.delete();
    send({5'b01000, 1'b0, 4'd7, 4'd0, 10'd0, 8'hAA});
    step(2);
    chk("ldi_count", 64'(seen_q.size()), 64'd1);
    if (seen_q.size() == 1) begin
      w_exp = {3'b001, 5'd0, 5'd7, 3'b000, 8'hAA, 2'b00, 8'h00, 10'h030};
      chk("ldi_u0", 64'(seen_q[0]), 64'(w_exp));
    end

    // illegal opcode then NOP
    seen_q.delete();
    send(32'hF8000000);
    chk("illegal_pulse", 64'(illegal_instr), 64'd1);
    chk("illegal_ready", 64'(instr_ready), 64'd1);
    send(32'h00000000);
    chk("nop_no_illegal", 64'(illegal_instr), 64'd0);
    chk("nop_ready", 64'(instr_ready), 64'd1);
    step(2);
    chk("ill_nop_uops", 64'(seen_q.size()), 64'd0);

    // rst mid-expansion
    minstr_ready = 1'b0;
    send(32'h08C48000);
    step(1);
    rst = 1'b1;
    step(1);
    chk("rst_mid_valid", 64'(minstr_valid), 64'd0);
    chk("rst_mid_out", 64'(minstr_out), 64'd0);
    chk("rst_mid_ready", 64'(instr_ready), 64'd1);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    step(1);

    // randomized traffic checked by the scoreboard
    for (int c = 0; c < 4000; c++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[31:27] = 5'($urandom_range(0, 10));
      instr_in     = ins;
      instr_valid  = ($urandom_range(0, 3) != 0);
      minstr_ready = ($urandom_range(0, 2) != 0);
      flush        = ($urandom_range(0, 39) == 0);
      rst          = ($urandom_range(0, 499) == 0);
      step(1);
    end
    instr_valid = 1'b0; flush = 1'b0; rst = 1'b0; minstr_ready = 1'b1;
    step(6);
    chk("drain_valid", 64'(minstr_valid), 64'd0);
    chk("drain_ready", 64'(instr_ready), 64'd1);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
